imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Program loader that writes a RISC-V instruction image into the datapath's instruction memory. The datapath is the reader of that memory; this block is its writer.
- Accepts 32-bit words over a valid/ready stream and issues single-cycle write strobes to instruction memory.
- Holds the datapath in reset during loading and releases it only after the image is complete.
- Sits between the bench or host stream and the datapath top, replacing the hard-coded reset pulse.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- DATA_WIDTH, 32, instruction word width.
- MAX_WORDS, 256, capacity in words; must be ≤ 2^ADDR_WIDTH.
- HOLD_CYCLES, 2, cycles the core stays in reset after the last write.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin or restart loading, sampled every cycle.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_WIDTH  stream word.
- in_last  in  1  qualifies the final word of the image.
- in_ready  out  1  loader can accept a word.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  DATA_WIDTH  write data.
- core_reset  out  1  active-high reset to the datapath.
- done  out  1  image loaded, core running.
- error  out  1  overflow occurred.
- word_count  out  ADDR_WIDTH+1  words written in the current load.

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-low: reset==0 at a rising edge clears all state.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0, word_count=0.
- States: IDLE, LOAD, HOLD, RUN, ERROR. State is registered. in_ready is decoded combinationally as (state==LOAD). All other outputs are registered.
- IDLE:
  - core_reset=1.
  - start=1 → LOAD; word_count←0; error←0.
- LOAD:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - If word_count < MAX_WORDS, the next cycle shows mem_we=1, mem_addr=word_count[ADDR_WIDTH-1:0], mem_wdata=in_data, and word_count increments. Write latency is 1 cycle.
  - Back-to-back transfers give consecutive mem_we pulses with no bubble.
  - mem_we=0 on any cycle without a preceding transfer. mem_addr and mem_wdata hold their last values.
  - A transfer with in_last=1 writes normally and moves to HOLD with the hold counter←HOLD_CYCLES.
  - A single word carrying in_last is a valid one-word image.
  - A transfer arriving when word_count==MAX_WORDS is dropped with no write, and the block moves to ERROR. in_last is ignored in that case.
  - start is ignored while in LOAD.
- HOLD:
  - in_ready=0, core_reset=1.
  - The counter decrements each cycle. When it reaches 0, the block moves to RUN.
  - This guarantees the final write has committed before the core fetches.
  - start is ignored while in HOLD.
- RUN:
  - core_reset=0, done=1.
  - start=1 → LOAD: core_reset=1 and done=0 on the next cycle, word_count←0. The core is re-held mid-execution; addresses restart at 0.
- ERROR:
  - error=1, core_reset=1, done=0, in_ready=0.
  - start=1 → LOAD, clearing error and word_count.
- Reset mid-operation: reset==0 in any state returns to the reset values on that edge. Any write pending for the next cycle is cancelled (mem_we=0).
- Width rules:
  - word_count saturates at MAX_WORDS and never wraps.
  - mem_addr uses the low ADDR_WIDTH bits of word_count.

Test Plan:
- Basic load: reset low 2 cycles, start pulse, stream 4 words 0x00000013, 0x00100093, 0x00200113, 0x002081B3 with last on the 4th.
  - Expect mem_we pulses at addr 0..3 with matching data and word_count=4.
  - Expect core_reset to fall exactly HOLD_CYCLES+1 cycles after the last transfer, with done=1.
- Backpressure and gaps: toggle in_valid 1,0,0,1,1 while in LOAD.
  - Expect exactly 3 writes, each one cycle after its transfer, and no write on idle cycles.
- Overflow: MAX_WORDS=4, stream 5 words with no last.
  - Expect 4 writes, no 5th write, error=1, core_reset=1, in_ready=0.
  - A subsequent start clears error, and a 1-word image reaches RUN.
- Reload while running: in RUN, pulse start.
  - Expect core_reset=1 and done=0 next cycle, word_count=0.
  - A new 2-word image writes addr 0,1 and returns to RUN.
- Reset mid-load: assert reset low on the same edge as a transfer during LOAD.
  - Expect mem_we=0 next cycle, state IDLE, all outputs at reset values, and start ignored while reset is low.
- Ignored start: pulse start during LOAD and during HOLD.
  - Expect no change to word_count, addresses, or the hold timing.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a RISC-V instruction image into instruction memory
// and keeps the datapath in reset until the image has fully committed.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_WORDS   = 256,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      wc_q, wc_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  xfer_c;

  // A word is accepted only while loading.
  assign in_ready = (state_q == S_LOAD);
  assign xfer_c   = in_valid && in_ready;

  // Next-state, write-strobe and status decode.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          wc_d    = '0;
        end
      end

      S_LOAD: begin
        if (xfer_c) begin
          if (wc_q < MAX_CNT) begin
            we_d    = 1'b1;
            addr_d  = wc_q[ADDR_WIDTH-1:0];
            wdata_d = in_data;
            wc_d    = wc_q + CNT_W'(1);
            if (in_last) begin
              state_d = S_HOLD;
              hold_d  = HOLD_INIT;
            end
          end else begin
            // Image larger than memory: drop the word, in_last is irrelevant.
            state_d = S_ERROR;
          end
        end
      end

      S_HOLD: begin
        // Counter expires one cycle after reaching zero so the last write
        // has landed before the core leaves reset.
        if (hold_q == '0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      S_RUN, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          wc_d    = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_reset_d = (state_d != S_RUN);
    done_d       = (state_d == S_RUN);
    error_d      = (state_d == S_ERROR);
  end

  // State and registered outputs; synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      wc_q         <= '0;
      hold_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      hold_q       <= hold_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a write scoreboard for imem_loader.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc_n = 0;

  imem_loader #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .MAX_WORDS  (4),
    .HOLD_CYCLES(2)
  ) dut (
    .clock      (clk),
    .reset      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Write monitor: every strobe must match the oldest expected write,
  // including the edge on which it was expected to appear.
  always @(negedge clk) begin
    if (mem_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL write_unexpected: got addr=%0d data=%h at cycle %0d, expected no write",
                 mem_addr, mem_wdata, cyc_n);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data || cyc_n != e.cyc) begin
          n_bad++;
          $display("FAIL write: got addr=%0d data=%h cycle=%0d, expected addr=%0d data=%h cycle=%0d",
                   mem_addr, mem_wdata, cyc_n, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer on the next edge; wr says whether a write must follow.
  task automatic xfer(input logic [31:0] d, input logic last, input logic [7:0] a, input logic wr);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (wr) exp_q.push_back('{addr: a, data: d, cyc: cyc_n + 1});
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Called right after the last transfer edge; core must leave reset on the third edge.
  task automatic check_hold(input string tag, input logic [8:0] wc, input logic poke_start);
    chk({tag, "_hold_wc"}, 64'(word_count), 64'(wc));
    chk({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
    if (poke_start) start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_hold1_core_reset"}, 64'(core_reset), 64'd1);
    step();
    chk({tag, "_hold2_core_reset"}, 64'(core_reset), 64'd1);
    chk({tag, "_hold2_done"}, 64'(done), 64'd0);
    step();
    chk({tag, "_run_core_reset"}, 64'(core_reset), 64'd0);
    chk({tag, "_run_done"}, 64'(done), 64'd1);
    chk({tag, "_run_wc"}, 64'(word_count), 64'(wc));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);

    // Basic 4-word load
    rst_n = 1'b1;
    step();
    chk("idle_ready", 64'(in_ready), 64'd0);
    pulse_start();
    chk("load_ready", 64'(in_ready), 64'd1);
    chk("load_core_reset", 64'(core_reset), 64'd1);
    xfer(32'h0000_0013, 1'b0, 8'd0, 1'b1);
    xfer(32'h0010_0093, 1'b0, 8'd1, 1'b1);
    xfer(32'h0020_0113, 1'b0, 8'd2, 1'b1);
    xfer(32'h0020_81B3, 1'b1, 8'd3, 1'b1);
    check_hold("basic", 9'd4, 1'b0);

    // Reload while running, 2-word image
    pulse_start();
    chk("reload_core_reset", 64'(core_reset), 64'd1);
    chk("reload_done", 64'(done), 64'd0);
    chk("reload_wc", 64'(word_count), 64'd0);
    chk("reload_ready", 64'(in_ready), 64'd1);
    xfer(32'hDEAD_0001, 1'b0, 8'd0, 1'b1);
    xfer(32'hDEAD_0002, 1'b1, 8'd1, 1'b1);
    check_hold("reload", 9'd2, 1'b0);

    // Gaps in the stream (valid 1,0,0,1,1) plus ignored start in LOAD and HOLD
    pulse_start();
    xfer(32'hA5A5_0000, 1'b0, 8'd0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gap1_wc", 64'(word_count), 64'd1);
    step();
    chk("gap2_we", 64'(mem_we), 64'd0);
    chk("gap2_wc", 64'(word_count), 64'd1);
    chk("gap2_addr_held", 64'(mem_addr), 64'd0);
    xfer(32'hA5A5_0001, 1'b0, 8'd1, 1'b1);
    xfer(32'hA5A5_0002, 1'b1, 8'd2, 1'b1);
    check_hold("gaps", 9'd3, 1'b1);

    // Overflow: 5 words into a 4-word memory
    pulse_start();
    xfer(32'h1111_0000, 1'b0, 8'd0, 1'b1);
    xfer(32'h1111_0001, 1'b0, 8'd1, 1'b1);
    xfer(32'h1111_0002, 1'b0, 8'd2, 1'b1);
    xfer(32'h1111_0003, 1'b0, 8'd3, 1'b1);
    chk("ovf_full_wc", 64'(word_count), 64'd4);
    chk("ovf_full_ready", 64'(in_ready), 64'd1);
    xfer(32'h1111_0004, 1'b1, 8'd0, 1'b0);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_core_reset", 64'(core_reset), 64'd1);
    chk("ovf_ready", 64'(in_ready), 64'd0);
    chk("ovf_done", 64'(done), 64'd0);
    chk("ovf_wc", 64'(word_count), 64'd4);
    step();
    chk("ovf_error_sticky", 64'(error), 64'd1);
    pulse_start();
    chk("ovf_clr_error", 64'(error), 64'd0);
    chk("ovf_clr_wc", 64'(word_count), 64'd0);
    xfer(32'h0000_006F, 1'b1, 8'd0, 1'b1);
    check_hold("one_word", 9'd1, 1'b0);

    // Reset asserted on the same edge as a transfer
    pulse_start();
    xfer(32'hCAFE_0000, 1'b0, 8'd0, 1'b1);
    rst_n = 1'b0;
    start = 1'b1;
    xfer(32'hCAFE_0001, 1'b0, 8'd1, 1'b0);
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_wdata", 64'(mem_wdata), 64'd0);
    chk("midrst_wc", 64'(word_count), 64'd0);
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_error", 64'(error), 64'd0);
    step();
    chk("midrst_start_ignored", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    chk("postrst_idle", 64'(in_ready), 64'd0);
    step();

    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
